// File: rtl/phase_detector_pkg.sv
// Shared types, record layout and width helpers for the multi-channel phase detector.
package phase_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } pd_state_t;

  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned TAG_LSB    = 0;

  // Channel-id field width; a single channel still carries a 1-bit id.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Total record width {ch_id, start_count, phase_tag}.
  function automatic int unsigned data_w(input int unsigned num_ch,
                                         input int unsigned start_w,
                                         input int unsigned phase_w);
    return ch_w(num_ch) + start_w + phase_w;
  endfunction

  // LSB of the start_count field.
  function automatic int unsigned start_lsb(input int unsigned phase_w);
    return TAG_LSB + phase_w;
  endfunction

  // LSB of the ch_id field.
  function automatic int unsigned ch_lsb(input int unsigned phase_w,
                                         input int unsigned start_w);
    return TAG_LSB + phase_w + start_w;
  endfunction

endpackage

// File: rtl/phase_fifo_sync.sv
// Single-clock FIFO with registered read data, level and status flags.
module phase_fifo_sync #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned LVL_W    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             almost_empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic             do_wr;
  logic             do_rd;
  logic [LVL_W-1:0] level_d;

  // Accept only legal transfers; flags are registered from the next level.
  always_comb begin
    do_wr   = wr_en & ~full;
    do_rd   = rd_en & ~empty;
    level_d = level;
    case ({do_wr, do_rd})
      2'b10:   level_d = level + LVL_W'(1);
      2'b01:   level_d = level - LVL_W'(1);
      default: level_d = level;
    endcase
  end

  // Pointers, read port and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      level        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_data  <= mem[rd_ptr_q];
      end
      rd_valid     <= do_rd;
      level        <= level_d;
      empty        <= (level_d == '0);
      almost_empty <= (level_d <= LVL_W'(AE_THRESH));
      full         <= (level_d == LVL_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care once pointers are reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/phase_detector_multi_fifo.sv
// Multi-channel ref-to-channel phase detector feeding a tagged-record FIFO.
module phase_detector_multi_fifo
  import phase_detector_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PHASE_W    = 5,
  parameter int unsigned START_W    = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AE_THRESH  = 2,
  localparam int unsigned CH_W      = ch_w(NUM_CH),
  localparam int unsigned DATA_W    = data_w(NUM_CH, START_W, PHASE_W),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_sample,
  input  logic                  rst,
  input  logic                  clk_in_0,
  input  logic [NUM_CH-1:0]     clk_in,
  input  logic                  clr_ovf,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned START_LSB = start_lsb(PHASE_W);
  localparam int unsigned CH_LSB    = ch_lsb(PHASE_W, START_W);
  localparam logic [PHASE_W-1:0] CNT_MAX = '1;

  logic [NUM_CH:0]                   sync1_q, sync2_q, sync3_q;
  logic                              ref_edge;
  logic [NUM_CH-1:0]                 ch_edge;
  logic [START_W-1:0]                ref_count_q;
  logic [NUM_CH-1:0]                 pend;
  logic [NUM_CH-1:0]                 grant;
  logic [NUM_CH-1:0][PHASE_W-1:0]    tag_all;
  logic [NUM_CH-1:0][START_W-1:0]    start_all;
  logic [CH_W-1:0]                   rr_q;
  logic [CH_W-1:0]                   cand;
  logic [CH_W-1:0]                   grant_idx;
  logic                              grant_vld;
  logic                              fifo_full;
  logic                              drop;
  logic [DATA_W-1:0]                 wr_data;

  // Two-flop synchronisers plus an edge-detect stage; bit 0 is the reference.
  always_ff @(posedge clk_sample) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= {clk_in, clk_in_0};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign ref_edge = sync2_q[0] & ~sync3_q[0];
  assign ch_edge  = sync2_q[NUM_CH:1] & ~sync3_q[NUM_CH:1];

  // Reference-edge counter; channels latch the pre-increment value.
  always_ff @(posedge clk_sample) begin
    if (!rst)          ref_count_q <= '0;
    else if (ref_edge) ref_count_q <= ref_count_q + START_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pd_state_t          state_q, state_d;
    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic [START_W-1:0] start_q, start_d;

    // Channel state register.
    always_ff @(posedge clk_sample) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        start_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        start_q <= start_d;
      end
    end

    // Measurement FSM: cnt doubles as the held tag while pending.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      case (state_q)
        IDLE: begin
          if (ref_edge) begin
            start_d = ref_count_q;
            if (ch_edge[i]) begin
              cnt_d   = '0;
              state_d = PEND;
            end else begin
              cnt_d   = PHASE_W'(1);
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (ch_edge[i]) begin
            state_d = PEND;
          end else if (ref_edge) begin
            cnt_d   = PHASE_W'(1);
            start_d = ref_count_q;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PHASE_W'(1);
          end
        end
        PEND: begin
          if (grant[i]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign pend[i]      = (state_q == PEND);
    assign tag_all[i]   = cnt_q;
    assign start_all[i] = start_q;
  end

  // Round-robin arbiter over pending channels, blocked while the FIFO is full.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(rr_q) + k) % NUM_CH);
      if (!grant_vld && !fifo_full && pend[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer moves past the winner so it has lowest priority next time.
  always_ff @(posedge clk_sample) begin
    if (!rst) begin
      rr_q <= '0;
    end else if (grant_vld) begin
      rr_q <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // Assemble the record for the granted channel.
  always_comb begin
    wr_data = '0;
    wr_data[CH_LSB +: CH_W]       = grant_idx;
    wr_data[START_LSB +: START_W] = start_all[grant_idx];
    wr_data[TAG_LSB +: PHASE_W]   = tag_all[grant_idx];
  end

  assign drop = ref_edge & (|pend);

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk_sample) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_count <= DROP_CNT_W'(1);
      else if (drop_count != '1)  drop_count <= drop_count + DROP_CNT_W'(1);
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  phase_fifo_sync #(
    .WIDTH    (DATA_W),
    .DEPTH    (FIFO_DEPTH),
    .AE_THRESH(AE_THRESH)
  ) u_fifo (
    .clk         (clk_sample),
    .rst_n       (rst),
    .wr_en       (grant_vld),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (data_out),
    .rd_valid    (rd_valid),
    .level       (level),
    .empty       (empty),
    .almost_empty(almost_empty),
    .full        (fifo_full)
  );

endmodule

// File: tb/tb_phase_detector_multi_fifo.sv
// Randomised scoreboard bench for phase_detector_multi_fifo (4 channels, 16-deep FIFO).
module tb_phase_detector_multi_fifo;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ref_pin;
  logic [3:0] ch_pin;
  logic       clr_ovf;
  logic       rd_en;
  logic [9:0] data_out;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  phase_detector_multi_fifo dut (
    .clk_sample  (clk),
    .rst         (rst),
    .clk_in_0    (ref_pin),
    .clk_in      (ch_pin),
    .clr_ovf     (clr_ovf),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: measurements expressed as cycle-time differences,
  // FIFO as a queue, input pins seen through a fixed detection latency.
  int         m_t = 0;
  int         m_mode [NCH];   // 0 idle, 1 measuring, 2 holding a result
  int         m_ref_cyc [NCH];
  int         m_start [NCH];
  int         m_tag [NCH];
  int         m_rr, m_rc, m_dc, g;
  bit         m_ovf, m_rdv, ref_e, full_now, rd_now, drp;
  logic [3:0] ch_e;
  logic [4:0] h1, h2, h3;
  logic [9:0] m_last;
  logic [9:0] m_fifo [$];
  logic [9:0] exp_q [$];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_ref_cyc[i] = 0; m_start[i] = 0; m_tag[i] = 0;
      end
      m_fifo.delete();
      m_rr = 0; m_rc = 0; m_ovf = 0; m_dc = 0; m_last = '0; m_rdv = 0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      ref_e    = h2[0] & ~h3[0];
      ch_e     = h2[4:1] & ~h3[4:1];
      full_now = (m_fifo.size() == DEPTH);
      rd_now   = rd_en && (m_fifo.size() != 0);
      g = -1;
      if (!full_now)
        for (int k = 0; k < NCH; k++)
          if (g < 0 && m_mode[(m_rr + k) % NCH] == 2) g = (m_rr + k) % NCH;
      drp = 0;
      for (int i = 0; i < NCH; i++) if (ref_e && m_mode[i] == 2) drp = 1;
      if (rd_now) begin
        m_last = m_fifo.pop_front();
        exp_q.push_back(m_last);
      end
      if (g >= 0) begin
        m_fifo.push_back(10'(g * 256 + m_start[g] * 32 + m_tag[g]));
        m_rr = (g + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++) begin
        case (m_mode[i])
          0: if (ref_e) begin
               m_start[i] = m_rc;
               if (ch_e[i]) begin m_tag[i] = 0; m_mode[i] = 2; end
               else begin m_ref_cyc[i] = m_t; m_mode[i] = 1; end
             end
          1: if (ch_e[i]) begin
               m_tag[i]  = (m_t - m_ref_cyc[i] > 31) ? 31 : m_t - m_ref_cyc[i];
               m_mode[i] = 2;
             end else if (ref_e) begin
               m_ref_cyc[i] = m_t;
               m_start[i]   = m_rc;
             end
          default: if (i == g) m_mode[i] = 0;
        endcase
      end
      if (ref_e) m_rc = (m_rc + 1) % 8;
      if (drp) begin
        m_ovf = 1;
        m_dc  = clr_ovf ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf = 0;
        m_dc  = 0;
      end
      m_rdv = rd_now;
      h3 = h2; h2 = h1; h1 = {ch_pin, ref_pin};
    end
    m_t++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  logic [9:0] exp_rec;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", level, m_fifo.size());
      chk("empty", empty, m_fifo.size() == 0);
      chk("almost_empty", almost_empty, m_fifo.size() <= 2);
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_dc);
      chk("rd_valid", rd_valid, m_rdv);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          exp_rec = exp_q.pop_front();
          chk("record", data_out, exp_rec);
        end
      end else begin
        chk("data_out_hold", data_out, m_last);
      end
    end
  end

  // One reference period: pins pulse high for two cycles at their offsets.
  task automatic run_period(input int per, input int d0, input int d1, input int d2,
                            input int d3, input logic [3:0] pres, input int rd_pct,
                            input int clr_pm, input int rst_at);
    int d [NCH];
    d = '{d0, d1, d2, d3};
    for (int c = 0; c < per; c++) begin
      @(negedge clk);
      ref_pin = (c < 2);
      for (int i = 0; i < NCH; i++) ch_pin[i] = pres[i] && (c >= d[i]) && (c < d[i] + 2);
      rd_en   = ($urandom_range(99, 0) < rd_pct);
      clr_ovf = ($urandom_range(999, 0) < clr_pm);
      rst     = !(rst_at >= 0 && c >= rst_at && c < rst_at + 2);
    end
  endtask

  initial begin
    int p, rp, ra;
    int rdp [4];
    logic [3:0] pr;
    rdp = '{0, 30, 70, 100};
    rst = 1'b0; ref_pin = 1'b0; ch_pin = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    mon_en = 1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    repeat (3) run_period(32, 3, 7, 12, 20, 4'hF, 100, 0, -1);
    repeat (3) run_period(32, 5, 5, 5, 5, 4'hF, 100, 0, -1);
    repeat (6) run_period(32, 4, 9, 15, 22, 4'hF, 0, 0, -1);
    @(negedge clk); rd_en = 1'b0; clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    repeat (3) run_period(32, 2, 6, 10, 14, 4'hF, 100, 0, -1);
    run_period(32, 9, 9, 9, 9, 4'b1110, 100, 0, -1);
    run_period(32, 9, 9, 9, 9, 4'hF, 100, 0, -1);
    repeat (2) run_period(32, 20, 21, 22, 23, 4'b0111, 0, 0, -1);
    run_period(32, 20, 21, 22, 23, 4'hF, 0, 0, 10);
    repeat (2) run_period(32, 3, 7, 12, 20, 4'hF, 100, 0, -1);
    run_period(40, 0, 35, 38, 17, 4'hF, 100, 0, -1);
    run_period(48, 45, 0, 40, 1, 4'b1011, 100, 0, -1);
    run_period(48, 45, 0, 40, 1, 4'hF, 100, 0, -1);

    for (int n = 0; n < 150; n++) begin
      p = $urandom_range(48, 6);
      for (int i = 0; i < NCH; i++) pr[i] = ($urandom_range(9, 0) < 8);
      rp = rdp[$urandom_range(3, 0)];
      ra = ($urandom_range(49, 0) == 0) ? $urandom_range(p - 1, 0) : -1;
      run_period(p, $urandom_range(p - 3, 0), $urandom_range(p - 3, 0),
                 $urandom_range(p - 3, 0), $urandom_range(p - 3, 0), pr, rp, 20, ra);
    end

    @(negedge clk);
    ref_pin = 1'b0; ch_pin = '0; rd_en = 1'b1; clr_ovf = 1'b0; rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_level", level, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_detector_multi_fifo.md
Name: phase_detector_multi_fifo

Overview:
- Parametrised multi-channel phase detector with an integrated single-clock FIFO.
- Measures, in clk_sample cycles, the delay from each rising edge of a reference input (clk_in_0) to the next rising edge of each of NUM_CH channel inputs.
- Each measurement is tagged with channel ID and reference-edge count, then buffered for readout on the same clock.
- Next generation of the single-channel start/stop phase detector plus dual-clock FIFO wrapper: adds channels, arbitration, real almost-empty, fill level and overflow reporting.

Parameters:
- NUM_CH, 4, number of measured channels (>=1).
- PHASE_W, 5, phase tag width.
- START_W, 3, reference-edge counter width.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >=4.
- AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH.

Ports:
- clk_sample  in  1  sample and system clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- clk_in_0  in  1  asynchronous reference input.
- clk_in  in  NUM_CH  asynchronous channel inputs.
- clr_ovf  in  1  clears overflow flag and drop_count.
- rd_en  in  1  FIFO read request.
- data_out  out  DATA_W  {ch_id[CH_W], start_count[START_W], phase_tag[PHASE_W]}.
  - CH_W = max(1, clog2(NUM_CH)).
  - DATA_W = CH_W + START_W + PHASE_W.
- rd_valid  out  1  data_out valid this cycle.
- empty  out  1  FIFO empty.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: at least one measurement dropped.
- drop_count  out  8  dropped-measurement count, saturating at 255.

Behaviour:
- Reset (rst=0 at clock edge) clears all state:
  - data_out=0, rd_valid=0, empty=1, almost_empty=1, level=0, overflow=0, drop_count=0.
  - All channel FSMs go to IDLE; ref_count=0; RR pointer=0; synchroniser flops=0.
  - Reset mid-operation discards FIFO contents and pending tags.
- Synchronisers:
  - Every async input passes through 2 flops, plus a third flop for edge detection.
  - Rising edge = stage2 & ~stage3.
  - Pin-to-detect latency is 2-3 cycles and is identical for all inputs, so it cancels in the measurement.
- ref_count (START_W bits):
  - On each reference edge, the value before increment is broadcast as start_val, then ref_count increments, wrapping mod 2^START_W.
  - The first reference edge after reset yields start_val=0.
- Per-channel FSM, states IDLE, COUNT, PEND:
  - IDLE:
    - On ref edge with a channel edge in the same cycle: tag=0, latch start_val, go to PEND.
    - On ref edge alone: cnt<=1, latch start_val, go to COUNT.
  - COUNT:
    - On channel edge: tag=cnt, go to PEND. A simultaneous ref edge is ignored (the channel edge wins).
    - On ref edge without a channel edge: restart the measurement (cnt<=1, relatch start_val). The old measurement is discarded silently.
    - Otherwise: cnt increments, saturating at 2^PHASE_W-1.
    - Phase semantics: tag = cycles between detected ref edge and detected channel edge.
  - PEND:
    - Holds the tag until granted; on grant, go to IDLE next cycle.
    - A ref edge while in PEND counts as one dropped measurement: overflow<=1, drop_count+1 (once per cycle even if several channels drop).
    - Channel edges are ignored in PEND.
- Arbiter:
  - Round-robin over PEND channels, one grant per cycle, combinational in the PEND cycle.
  - Search starts at the RR pointer; after a grant the pointer becomes granted+1 mod NUM_CH.
  - No grant while full=1. Full gates writes even when rd_en is high in the same cycle.
  - Grant writes {ch, start, tag} into the FIFO at the same clock edge.
  - Earliest latency: channel edge detected at t -> PEND at t+1 -> written at end of t+1 -> empty=0 at t+2.
- FIFO:
  - Synchronous; internal full = (level == FIFO_DEPTH).
  - A read with rd_en=1 and empty=0 at edge t gives data_out and rd_valid=1 during t+1; rd_valid=0 otherwise, and data_out holds its last value.
  - rd_en while empty is ignored; a simultaneous write still proceeds.
  - Simultaneous read and write when not full and not empty: level unchanged.
  - Pointers wrap mod FIFO_DEPTH.
- clr_ovf:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.

Decomposition:
- Package phase_detector_pkg:
  - pd_state_t enum {IDLE, COUNT, PEND}.
  - Helper functions for ch_w and data_w.
  - Record field offset constants.
- Sub-module phase_fifo_sync (parametrised WIDTH, DEPTH, AE_THRESH) provides the FIFO storage, level, empty, almost_empty and full.
- Synchronisers, channel FSMs (generate loop) and arbiter live in the top module.

Test Plan:
- NUM_CH=4; reference period 32 cycles; channels delayed 3/7/12/20 cycles -> FIFO records for start 0 read back in order ch0..ch3 with phase_tag 3,7,12,20 and start_count 0.
- All 4 channels edge in the same cycle at offset 5 -> four writes on consecutive cycles in RR order 0,1,2,3; next simultaneous burst is granted starting with ch0 again (pointer wrapped), all tags 5.
- No reads for 5 reference periods, 4 channels (20 tags > 16 entries) -> level=16; tags held in PEND; overflow=1 and drop_count>=1 after the next ref edge. clr_ovf -> both 0.
- Channel edge absent for one period, then present at offset 9 -> no record for the missing period; next record has tag 9 and start_count incremented by 2.
- rst=0 asserted with FIFO level 6 and channels in COUNT -> next cycle empty=1, level=0, almost_empty=1, data_out=0; first post-reset record has start_count 0.
- rd_en held with FIFO empty, then one write -> rd_valid stays 0 until the write; empty falls, rd_valid=1 one cycle after the accepted read; level 0->1->0.
